pipeline_step_controller: RTL and testbench

Sequences the debug pipeline from UART command bytes: holds it in reset, runs it continuously or one cycle at a time via a clock-enable, and stops it on program end or watchdog expiry. After each run or step it triggers the debug transmitter to dump pipeline state and waits for completion. Sits between the UART receive side, the end-of-program detector, the pipeline and the debug transmitter.

---
 rtl/pipeline_step_controller_pkg.sv | 33 +++
 rtl/pipeline_step_controller_cycle_counter.sv | 43 ++++
 rtl/pipeline_step_controller.sv | 169 ++++++++++++++++
 tb/tb_pipeline_step_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_step_controller_pkg.sv
// Shared definitions for the debug pipeline step controller: FSM state
// encoding, UART command bytes and the counter saturation helper.
package pipeline_step_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESET   = 3'd1,
    ST_WAIT_CMD = 3'd2,
    ST_RUN      = 3'd3,
    ST_STEP     = 3'd4,
    ST_SEND     = 3'd5,
    ST_WAIT_TX  = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  localparam logic [7:0] CMD_CONT  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
  localparam logic [7:0] CMD_RESET = 8'h72;  // 'r'

  localparam int unsigned CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == {CNT_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/pipeline_step_controller_cycle_counter.sv
// Saturating pipeline cycle counter. The limit compare looks at the value the
// counter will hold after this edge, so the controller can stop the pipeline
// enable in the same cycle the last permitted cycle is counted.
module pipe_cycle_counter
  import pipeline_step_controller_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_limit_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over increment, increment saturates.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {CNT_W{1'b0}};
    end else if (inc_i) begin
      count_d = sat_inc(count_q);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_d == limit_i);

endmodule

// File: rtl/pipeline_step_controller.sv
// Debug pipeline sequencer: decodes UART command bytes to hold the pipeline in
// reset, run it freely or single-step it, then triggers a state dump and waits
// for the transmitter. All outputs come straight from registers.
module pipeline_step_controller
  import pipeline_step_controller_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned MAX_CYCLES   = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_rd,
  input  logic        program_finished,
  input  logic        data_sent,
  output logic        pipe_clk_en,
  output logic        pipe_reset,
  output logic        send_signal,
  output logic [15:0] cycle_count,
  output logic        timeout,
  output logic [2:0]  current_state
);

  localparam logic [15:0] PRESET_LAST = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] WD_LIMIT    = 16'(MAX_CYCLES);

  state_e      state_q;
  logic [15:0] preset_cnt_q;
  logic        cmd_rd_q;
  logic        pipe_clk_en_q;
  logic        pipe_reset_q;
  logic        send_q;
  logic        timeout_q;

  logic        cmd_take_s;
  logic        cnt_clear_s;
  logic        cnt_at_limit_s;
  logic [15:0] cnt_value_s;

  // A byte is taken only in the command-accepting states, and never in the
  // cycle right after a consume, while the receiver still shows the old byte.
  assign cmd_take_s  = cmd_valid && !cmd_rd_q &&
                       ((state_q == ST_WAIT_CMD) || (state_q == ST_DONE));
  // Counter clears on every way into PRESET.
  assign cnt_clear_s = (state_q == ST_IDLE) ||
                       (cmd_take_s && (cmd_data == CMD_RESET));

  pipe_cycle_counter u_cycle_counter (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (cnt_clear_s),
    .inc_i      (pipe_clk_en_q),
    .limit_i    (WD_LIMIT),
    .count_o    (cnt_value_s),
    .at_limit_o (cnt_at_limit_s)
  );

  // Sequencer FSM with registered control outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      preset_cnt_q  <= 16'd0;
      cmd_rd_q      <= 1'b0;
      pipe_clk_en_q <= 1'b0;
      pipe_reset_q  <= 1'b1;
      send_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      cmd_rd_q      <= 1'b0;
      pipe_clk_en_q <= 1'b0;
      send_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          state_q      <= ST_PRESET;
          preset_cnt_q <= 16'd0;
          pipe_reset_q <= 1'b1;
          timeout_q    <= 1'b0;
        end
        ST_PRESET: begin
          if (preset_cnt_q == PRESET_LAST) begin
            state_q      <= ST_WAIT_CMD;
            pipe_reset_q <= 1'b0;
          end else begin
            preset_cnt_q <= preset_cnt_q + 16'd1;
          end
        end
        ST_WAIT_CMD: begin
          if (cmd_take_s) begin
            cmd_rd_q <= 1'b1;
            case (cmd_data)
              CMD_CONT: begin
                state_q       <= ST_RUN;
                pipe_clk_en_q <= !(program_finished || cnt_at_limit_s);
              end
              CMD_STEP: begin
                state_q       <= ST_STEP;
                pipe_clk_en_q <= !program_finished;
              end
              CMD_RESET: begin
                state_q      <= ST_PRESET;
                preset_cnt_q <= 16'd0;
                pipe_reset_q <= 1'b1;
                timeout_q    <= 1'b0;
              end
              default: begin
                state_q <= ST_WAIT_CMD;
              end
            endcase
          end else begin
            state_q <= ST_WAIT_CMD;
          end
        end
        ST_RUN: begin
          // at_limit reflects the count including this cycle's enable.
          if (program_finished || cnt_at_limit_s) begin
            state_q   <= ST_SEND;
            send_q    <= 1'b1;
            timeout_q <= timeout_q | cnt_at_limit_s;
          end else begin
            pipe_clk_en_q <= 1'b1;
          end
        end
        ST_STEP: begin
          state_q <= ST_SEND;
          send_q  <= 1'b1;
        end
        ST_SEND: begin
          state_q <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (data_sent) begin
            state_q <= (program_finished || timeout_q) ? ST_DONE : ST_WAIT_CMD;
          end else begin
            state_q <= ST_WAIT_TX;
          end
        end
        ST_DONE: begin
          if (cmd_take_s) begin
            cmd_rd_q <= 1'b1;
            if (cmd_data == CMD_RESET) begin
              state_q      <= ST_PRESET;
              preset_cnt_q <= 16'd0;
              pipe_reset_q <= 1'b1;
              timeout_q    <= 1'b0;
            end else begin
              state_q <= ST_DONE;
            end
          end else begin
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          pipe_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_rd        = cmd_rd_q;
  assign pipe_clk_en   = pipe_clk_en_q;
  assign pipe_reset    = pipe_reset_q;
  assign send_signal   = send_q;
  assign cycle_count   = cnt_value_s;
  assign timeout       = timeout_q;
  assign current_state = state_q;

endmodule

// File: tb/tb_pipeline_step_controller.sv
// Self-checking bench for pipeline_step_controller: directed scenarios followed
// by a random command stream, checked against a per-command outcome model.
module tb_pipeline_step_controller;
  import pipeline_step_controller_pkg::*;

  localparam int unsigned TB_MAX = 40;
  localparam int unsigned TB_RST = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_valid = 1'b0;
  logic        cmd_rd;
  logic        program_finished = 1'b0;
  logic        data_sent = 1'b0;
  logic        pipe_clk_en;
  logic        pipe_reset;
  logic        send_signal;
  logic [15:0] cycle_count;
  logic        timeout;
  logic [2:0]  current_state;

  pipeline_step_controller #(
    .RESET_CYCLES (TB_RST),
    .MAX_CYCLES   (TB_MAX)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .cmd_data         (cmd_data),
    .cmd_valid        (cmd_valid),
    .cmd_rd           (cmd_rd),
    .program_finished (program_finished),
    .data_sent        (data_sent),
    .pipe_clk_en      (pipe_clk_en),
    .pipe_reset       (pipe_reset),
    .send_signal      (send_signal),
    .cycle_count      (cycle_count),
    .timeout          (timeout),
    .current_state    (current_state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int en_seen, send_seen, rd_seen, preset_seen;

  // Reference model: outcome of each command at transaction level.
  int m_count;
  bit m_timeout;
  bit m_done;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic clear_seen();
    en_seen = 0; send_seen = 0; rd_seen = 0; preset_seen = 0;
  endtask

  // Advance one clock and sample outputs on the falling edge.
  task automatic step_cycle();
    @(negedge clock);
    if (pipe_clk_en) en_seen++;
    if (send_signal) send_seen++;
    if (cmd_rd) rd_seen++;
    if (pipe_reset && current_state == 3'd1) preset_seen++;
    if (pipe_clk_en) chk("en_while_pipe_reset", pipe_reset, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; program_finished = 1'b0; data_sent = 1'b0;
    step_cycle();
    step_cycle();
    chk("rst_state", current_state, 0);
    chk("rst_pipe_reset", pipe_reset, 1);
    chk("rst_cmd_rd", cmd_rd, 0);
    chk("rst_clk_en", pipe_clk_en, 0);
    chk("rst_send", send_signal, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;
    clear_seen();
    for (int i = 0; i < 20 && current_state != 3'd2; i++) step_cycle();
    chk("preset_cycles", preset_seen, TB_RST);
    chk("after_preset_state", current_state, 2);
    chk("after_preset_pipe_reset", pipe_reset, 0);
    chk("after_preset_count", cycle_count, 0);
    chk("after_preset_timeout", timeout, 0);
    m_count = 0; m_timeout = 1'b0; m_done = 1'b0;
  endtask

  // Issue one command byte; pf_at>0 raises program_finished after that many
  // enable cycles of a continuous run (0 = never).
  task automatic exec_cmd(input logic [7:0] b, input int pf_at);
    bit exp_send = 1'b0;
    bit is_run = 1'b0;
    bit is_rst = 1'b0;
    int exp_en = 0;
    int lim;
    int bound;
    bit pf_now = program_finished;

    if (b == CMD_RESET) begin
      is_rst = 1'b1;
      m_count = 0; m_timeout = 1'b0; m_done = 1'b0;
    end else if (!m_done && b == CMD_STEP) begin
      exp_send = 1'b1;
      exp_en = pf_now ? 0 : 1;
      m_count = sat16(m_count + exp_en);
      m_done = pf_now || m_timeout;
    end else if (!m_done && b == CMD_CONT) begin
      exp_send = 1'b1;
      is_run = 1'b1;
      if (m_count < TB_MAX) lim = TB_MAX - m_count;
      else if (m_count == TB_MAX) lim = 0;
      else lim = -1;
      if (lim >= 0 && (pf_at == 0 || lim <= pf_at)) begin
        exp_en = lim; m_timeout = 1'b1;
      end else begin
        exp_en = pf_at;
      end
      m_count = sat16(m_count + exp_en);
      m_done = 1'b1;
    end

    if (is_rst) program_finished = 1'b0;
    cmd_data = b; cmd_valid = 1'b1;
    clear_seen();
    bound = exp_send ? (TB_MAX + 60) : 8;
    for (int i = 0; i < bound && !(exp_send && send_seen != 0); i++) begin
      step_cycle();
      if (rd_seen != 0) cmd_valid = 1'b0;
      if (is_run && pf_at > 0 && en_seen == pf_at) program_finished = 1'b1;
    end
    cmd_valid = 1'b0;
    if (exp_send) begin
      int w = $urandom_range(1, 3);
      for (int i = 0; i < w; i++) step_cycle();
      chk("wait_tx_state", current_state, 6);
      data_sent = 1'b1;
      step_cycle();
      data_sent = 1'b0;
    end
    if (is_rst) chk("cmd_preset_cycles", preset_seen, TB_RST);
    chk("cmd_rd_pulses", rd_seen, 1);
    chk("clk_en_cycles", en_seen, exp_en);
    chk("send_pulses", send_seen, exp_send ? 1 : 0);
    chk("state_after_cmd", current_state, m_done ? 7 : 2);
    chk("cycle_count", cycle_count, m_count);
    chk("timeout_flag", timeout, m_timeout);
  endtask

  initial begin
    logic [7:0] b;
    int r, pf_at;

    // Reset and PRESET sequence.
    do_reset();

    // Unknown byte consumed and ignored.
    exec_cmd(8'h41, 0);

    // Stray data_sent in WAIT_CMD has no effect.
    data_sent = 1'b1;
    step_cycle();
    data_sent = 1'b0;
    step_cycle();
    chk("stray_data_sent_state", current_state, 2);

    // Single step.
    exec_cmd(CMD_STEP, 0);

    // Continuous run ending on program end after 37 cycles.
    exec_cmd(CMD_RESET, 0);
    exec_cmd(CMD_CONT, 37);
    exec_cmd(CMD_STEP, 0);   // ignored in DONE

    // Watchdog expiry, then recovery.
    exec_cmd(CMD_RESET, 0);
    exec_cmd(CMD_CONT, 0);
    exec_cmd(CMD_RESET, 0);

    // Program end and watchdog in the same cycle.
    exec_cmd(CMD_CONT, TB_MAX);
    exec_cmd(CMD_RESET, 0);

    // Step with program already finished: no enable, then DONE.
    program_finished = 1'b1;
    exec_cmd(CMD_STEP, 0);
    exec_cmd(CMD_RESET, 0);

    // Reset in the middle of a continuous run.
    cmd_data = CMD_CONT; cmd_valid = 1'b1;
    clear_seen();
    for (int i = 0; i < 30 && cycle_count != 16'd5; i++) begin
      step_cycle();
      if (rd_seen != 0) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    chk("midrun_state", current_state, 3);
    chk("midrun_count", cycle_count, 5);
    reset = 1'b1;
    step_cycle();
    chk("midrun_rst_state", current_state, 0);
    chk("midrun_rst_pipe_reset", pipe_reset, 1);
    chk("midrun_rst_clk_en", pipe_clk_en, 0);
    chk("midrun_rst_count", cycle_count, 0);
    do_reset();

    // Random command stream.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (m_done) begin
        if (r < 6) b = CMD_RESET;
        else if (r == 6) b = CMD_STEP;
        else if (r == 7) b = CMD_CONT;
        else b = 8'($urandom_range(0, 255));
      end else begin
        if (r < 3) b = CMD_STEP;
        else if (r < 6) b = CMD_CONT;
        else if (r == 6) b = CMD_RESET;
        else if (r == 7) b = 8'h41;
        else b = 8'($urandom_range(0, 255));
        if (b == CMD_STEP) program_finished = ($urandom_range(0, 4) == 0);
      end
      if (m_count <= TB_MAX && $urandom_range(0, 3) == 0) pf_at = 0;
      else pf_at = $urandom_range(1, 50);
      exec_cmd(b, pf_at);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
